// File: rtl/slc3_mem_ctrl.sv
// SLC-3 SRAM bus controller: turns level Mem_OE/Mem_WE requests into timed async-SRAM cycles.
// Define SLC3_MMIO_EN to decode MAR=x"FFFF" as switches (read) / hex display (write).
module slc3_mem_ctrl #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_out,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic        Data_valid,
    output logic        Busy,
    output logic [15:0] HEX_data,
    output logic [19:0] SRAM_ADDR,
    input  logic [15:0] SRAM_DQ_in,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [15:0]        addr_reg, addr_next;
    logic [15:0]        dq_out_reg, dq_out_next;
    logic [15:0]        data_reg, data_next;
    logic [15:0]        hex_reg, hex_next;
    logic               dq_oe_reg, dq_oe_next;
    logic               valid_reg, valid_next;
    logic               busy_reg, busy_next;
    logic               ce_n_reg, ce_n_next;
    logic               oe_n_reg, oe_n_next;
    logic               we_n_reg, we_n_next;
    logic               mmio_hit;

`ifdef SLC3_MMIO_EN
    assign mmio_hit = (MAR == 16'hFFFF);
`else
    assign mmio_hit = 1'b0;
    wire unused_switches = ^Switches;
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        addr_next   = addr_reg;
        dq_out_next = dq_out_reg;
        data_next   = data_reg;
        hex_next    = hex_reg;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                // Write has priority when both requests arrive together.
                if (Mem_WE) begin
                    if (mmio_hit) begin
                        hex_next   = MDR_out;
                        state_next = DONE;
                    end else begin
                        addr_next   = MAR;
                        dq_out_next = MDR_out;
                        state_next  = WR_SETUP;
                    end
                end else if (Mem_OE) begin
                    if (mmio_hit) begin
                        data_next  = Switches;
                        state_next = DONE;
                    end else begin
                        addr_next  = MAR;
                        state_next = RD;
                    end
                end
            end
            RD: begin
                if (cnt_reg == CNT_W'(RD_WAIT - 1)) begin
                    data_next  = SRAM_DQ_in;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WR_SETUP: begin
                cnt_next   = '0;
                state_next = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_reg == CNT_W'(WR_WAIT - 1)) begin
                    state_next = WR_HOLD;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WR_HOLD: begin
                state_next = DONE;
            end
            DONE: begin
                // Hold here until the request level drops so one level = one access.
                if (!Mem_OE && !Mem_WE) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Pin values are decoded from the next state so the pins are registered.
        busy_next  = (state_next == RD) || (state_next == WR_SETUP) ||
                     (state_next == WR_PULSE) || (state_next == WR_HOLD);
        ce_n_next  = !busy_next;
        oe_n_next  = (state_next != RD);
        we_n_next  = (state_next != WR_PULSE);
        dq_oe_next = (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                     (state_next == WR_HOLD);
        valid_next = (state_next == DONE) && (state_reg != DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            dq_out_reg <= '0;
            data_reg   <= '0;
            hex_reg    <= '0;
            dq_oe_reg  <= 1'b0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            ce_n_reg   <= 1'b1;
            oe_n_reg   <= 1'b1;
            we_n_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            addr_reg   <= addr_next;
            dq_out_reg <= dq_out_next;
            data_reg   <= data_next;
            hex_reg    <= hex_next;
            dq_oe_reg  <= dq_oe_next;
            valid_reg  <= valid_next;
            busy_reg   <= busy_next;
            ce_n_reg   <= ce_n_next;
            oe_n_reg   <= oe_n_next;
            we_n_reg   <= we_n_next;
        end
    end

    assign Data_to_CPU = data_reg;
    assign Data_valid  = valid_reg;
    assign Busy        = busy_reg;
    assign HEX_data    = hex_reg;
    assign SRAM_ADDR   = {4'b0000, addr_reg};
    assign SRAM_DQ_out = dq_out_reg;
    assign SRAM_DQ_oe  = dq_oe_reg;
    assign SRAM_CE_N   = ce_n_reg;
    assign SRAM_OE_N   = oe_n_reg;
    assign SRAM_WE_N   = we_n_reg;
    // Both byte lanes are always enabled together with chip enable.
    assign SRAM_UB_N   = ce_n_reg;
    assign SRAM_LB_N   = ce_n_reg;

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Self-checking bench for slc3_mem_ctrl: read data expectations go through a scoreboard queue,
// pin timing is checked per scenario from cycle-by-cycle activity counts.
module tb_slc3_mem_ctrl;

    logic        Clk;
    logic        Reset;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] MAR;
    logic [15:0] MDR_out;
    logic [15:0] Switches;
    logic [15:0] Data_to_CPU;
    logic        Data_valid;
    logic        Busy;
    logic [15:0] HEX_data;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_in;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    slc3_mem_ctrl #(.RD_WAIT(2), .WR_WAIT(2)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Mem_OE      (Mem_OE),
        .Mem_WE      (Mem_WE),
        .MAR         (MAR),
        .MDR_out     (MDR_out),
        .Switches    (Switches),
        .Data_to_CPU (Data_to_CPU),
        .Data_valid  (Data_valid),
        .Busy        (Busy),
        .HEX_data    (HEX_data),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_in  (SRAM_DQ_in),
        .SRAM_DQ_out (SRAM_DQ_out),
        .SRAM_DQ_oe  (SRAM_DQ_oe),
        .SRAM_CE_N   (SRAM_CE_N),
        .SRAM_OE_N   (SRAM_OE_N),
        .SRAM_WE_N   (SRAM_WE_N),
        .SRAM_UB_N   (SRAM_UB_N),
        .SRAM_LB_N   (SRAM_LB_N)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_mis = 0;

    logic [15:0] exp_q[$];
    logic [15:0] model_data = 16'h0000;

    // Scoreboard: every Data_valid pulse pops one expected Data_to_CPU value.
    always @(negedge Clk) begin
        if (Data_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL sb_unexpected_valid: got pulse with data %h, want no pulse", Data_to_CPU);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (Data_to_CPU !== e) begin
                    n_mis++;
                    $display("FAIL sb_data: got %h, want %h", Data_to_CPU, e);
                end
            end
        end
    end

    int          cyc, n_ce, n_oe, n_we, n_dq, n_busy, n_valid;
    int          first_oe, first_we, valid_cyc;
    logic [19:0] last_addr;
    logic [15:0] we_data;

    task automatic clear_watch();
        cyc = 0; n_ce = 0; n_oe = 0; n_we = 0; n_dq = 0; n_busy = 0; n_valid = 0;
        first_oe = -1; first_we = -1; valid_cyc = -1;
        last_addr = 20'hxxxxx; we_data = 16'hxxxx;
    endtask

    task automatic tick_watch();
        @(negedge Clk);
        cyc++;
        if (!SRAM_CE_N) begin n_ce++; last_addr = SRAM_ADDR; end
        if (!SRAM_OE_N) begin n_oe++; if (first_oe < 0) first_oe = cyc; end
        if (!SRAM_WE_N) begin n_we++; if (first_we < 0) first_we = cyc; we_data = SRAM_DQ_out; end
        if (SRAM_DQ_oe) n_dq++;
        if (Busy) n_busy++;
        if (Data_valid) begin n_valid++; valid_cyc = cyc; end
    endtask

    task automatic go_idle(input int n);
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0;
        MAR = '0; MDR_out = '0; Switches = '0; SRAM_DQ_in = '0;
        repeat (3) @(negedge Clk);
        n_vec++;
        if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11111 ||
            SRAM_DQ_oe !== 1'b0 || Busy !== 1'b0 || Data_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_ctrl: got n=%b oe=%b busy=%b valid=%b, want n=11111 oe=0 busy=0 valid=0",
                     {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, SRAM_DQ_oe, Busy, Data_valid);
        end
        n_vec++;
        if (Data_to_CPU !== 16'h0 || HEX_data !== 16'h0 || SRAM_ADDR !== 20'h0 || SRAM_DQ_out !== 16'h0) begin
            n_mis++;
            $display("FAIL reset_data: got d=%h hex=%h addr=%h dq=%h, want all zero",
                     Data_to_CPU, HEX_data, SRAM_ADDR, SRAM_DQ_out);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_read();
        clear_watch();
        Mem_OE = 1'b1; MAR = 16'h0003; SRAM_DQ_in = 16'hDEAD;
        exp_q.push_back(16'h1234); model_data = 16'h1234;
        for (int i = 1; i <= 10; i++) begin
            tick_watch();
            if (i == 1) MAR = 16'h7777;
            if (i == 2) SRAM_DQ_in = 16'h1234;
            if (i == 4) Mem_OE = 1'b0;
        end
        n_vec++;
        if (n_oe !== 2 || first_oe !== 1) begin
            n_mis++; $display("FAIL rd_oe_timing: got %0d cycles from %0d, want 2 from 1", n_oe, first_oe);
        end
        n_vec++;
        if (n_valid !== 1 || valid_cyc !== 3) begin
            n_mis++; $display("FAIL rd_valid: got %0d pulses at %0d, want 1 at 3", n_valid, valid_cyc);
        end
        n_vec++;
        if (last_addr !== 20'h00003 || n_busy !== 2 || n_we !== 0) begin
            n_mis++; $display("FAIL rd_addr_busy: got addr=%h busy=%0d we=%0d, want 00003 2 0", last_addr, n_busy, n_we);
        end
    endtask

    task automatic test_write();
        clear_watch();
        Mem_WE = 1'b1; MAR = 16'h0010; MDR_out = 16'hBEEF;
        exp_q.push_back(model_data);
        for (int i = 1; i <= 9; i++) begin
            tick_watch();
            if (i == 1) begin MAR = 16'h5555; MDR_out = 16'h1111; end
            if (i == 6) Mem_WE = 1'b0;
        end
        n_vec++;
        if (n_we !== 2 || first_we !== 2) begin
            n_mis++; $display("FAIL wr_we_timing: got %0d cycles from %0d, want 2 from 2", n_we, first_we);
        end
        n_vec++;
        if (n_dq !== 4 || n_ce !== 4 || n_oe !== 0) begin
            n_mis++; $display("FAIL wr_pins: got dq_oe=%0d ce=%0d oe=%0d, want 4 4 0", n_dq, n_ce, n_oe);
        end
        n_vec++;
        if (we_data !== 16'hBEEF || last_addr !== 20'h00010) begin
            n_mis++; $display("FAIL wr_data_addr: got %h @ %h, want BEEF @ 00010", we_data, last_addr);
        end
        n_vec++;
        if (n_valid !== 1 || valid_cyc !== 5 || Data_to_CPU !== model_data) begin
            n_mis++; $display("FAIL wr_done: got %0d pulses at %0d data %h, want 1 at 5 data %h",
                              n_valid, valid_cyc, Data_to_CPU, model_data);
        end
    endtask

    task automatic test_both();
        clear_watch();
        Mem_WE = 1'b1; Mem_OE = 1'b1; MAR = 16'h0020; MDR_out = 16'h5A5A; SRAM_DQ_in = 16'h9999;
        exp_q.push_back(model_data);
        for (int i = 1; i <= 9; i++) begin
            tick_watch();
            if (i == 6) begin Mem_WE = 1'b0; Mem_OE = 1'b0; end
        end
        n_vec++;
        if (n_oe !== 0 || n_we !== 2 || n_valid !== 1) begin
            n_mis++; $display("FAIL both_write_wins: got oe=%0d we=%0d valid=%0d, want 0 2 1", n_oe, n_we, n_valid);
        end
        n_vec++;
        if (we_data !== 16'h5A5A || Data_to_CPU !== model_data) begin
            n_mis++; $display("FAIL both_data: got dq=%h d=%h, want 5A5A %h", we_data, Data_to_CPU, model_data);
        end
    endtask

    task automatic test_back_to_back();
        clear_watch();
        Mem_OE = 1'b1; MAR = 16'h0003; SRAM_DQ_in = 16'hABCD;
        exp_q.push_back(16'hABCD); model_data = 16'hABCD;
        for (int i = 0; i < 20 && !Data_valid; i++) tick_watch();
        n_vec++;
        if (!Data_valid) begin
            n_mis++; $display("FAIL b2b_first_timeout: got no Data_valid, want pulse within 20 cycles");
        end
        Mem_OE = 1'b0;
        @(negedge Clk);
        clear_watch();
        Mem_OE = 1'b1; MAR = 16'h0004; SRAM_DQ_in = 16'h4444;
        exp_q.push_back(16'h4444); model_data = 16'h4444;
        for (int i = 1; i <= 6; i++) tick_watch();
        Mem_OE = 1'b0;
        n_vec++;
        if (first_oe !== 1 || n_oe !== 2 || last_addr !== 20'h00004) begin
            n_mis++; $display("FAIL b2b_second: got start %0d len %0d addr %h, want 1 2 00004", first_oe, n_oe, last_addr);
        end
        n_vec++;
        if (valid_cyc !== 3) begin
            n_mis++; $display("FAIL b2b_latency: got valid at %0d, want 3", valid_cyc);
        end
    endtask

    task automatic test_mmio();
`ifdef SLC3_MMIO_EN
        clear_watch();
        Mem_WE = 1'b1; MAR = 16'hFFFF; MDR_out = 16'h00AB;
        exp_q.push_back(model_data);
        for (int i = 1; i <= 4; i++) begin
            tick_watch();
            if (i == 2) Mem_WE = 1'b0;
        end
        n_vec++;
        if (HEX_data !== 16'h00AB || n_ce !== 0 || valid_cyc !== 1) begin
            n_mis++; $display("FAIL mmio_write: got hex=%h ce=%0d valid@%0d, want 00AB 0 1", HEX_data, n_ce, valid_cyc);
        end
        clear_watch();
        Mem_OE = 1'b1; MAR = 16'hFFFF; Switches = 16'h0F0F; SRAM_DQ_in = 16'h7777;
        exp_q.push_back(16'h0F0F); model_data = 16'h0F0F;
        for (int i = 1; i <= 4; i++) begin
            tick_watch();
            if (i == 2) Mem_OE = 1'b0;
        end
        n_vec++;
        if (valid_cyc !== 1 || n_ce !== 0 || n_oe !== 0) begin
            n_mis++; $display("FAIL mmio_read: got valid@%0d ce=%0d oe=%0d, want 1 0 0", valid_cyc, n_ce, n_oe);
        end
`else
        clear_watch();
        Mem_WE = 1'b1; MAR = 16'hFFFF; MDR_out = 16'h00AB;
        exp_q.push_back(model_data);
        for (int i = 1; i <= 8; i++) begin
            tick_watch();
            if (i == 6) Mem_WE = 1'b0;
        end
        n_vec++;
        if (HEX_data !== 16'h0000 || n_ce !== 4 || last_addr !== 20'h0FFFF) begin
            n_mis++; $display("FAIL ffff_is_sram: got hex=%h ce=%0d addr=%h, want 0000 4 0FFFF", HEX_data, n_ce, last_addr);
        end
`endif
    endtask

    task automatic test_reset_mid_read();
        clear_watch();
        Mem_OE = 1'b1; MAR = 16'h0030; SRAM_DQ_in = 16'h6666;
        tick_watch();
        n_vec++;
        if (SRAM_OE_N !== 1'b0) begin
            n_mis++; $display("FAIL rst_mid_rd_start: got OE_N=%b, want 0", SRAM_OE_N);
        end
        Reset = 1'b1; Mem_OE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_vec++;
            if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11111 ||
                SRAM_DQ_oe !== 1'b0 || Busy !== 1'b0 || Data_valid !== 1'b0 || Data_to_CPU !== 16'h0) begin
                n_mis++;
                $display("FAIL rst_mid_rd_%0d: got n=%b oe=%b busy=%b valid=%b d=%h, want 11111 0 0 0 0000",
                         i, {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N},
                         SRAM_DQ_oe, Busy, Data_valid, Data_to_CPU);
            end
        end
        model_data = 16'h0000;
        Reset = 1'b0;
        clear_watch();
        for (int i = 0; i < 4; i++) tick_watch();
        n_vec++;
        if (n_ce !== 0 || n_valid !== 0) begin
            n_mis++; $display("FAIL rst_no_retry: got ce=%0d valid=%0d, want 0 0", n_ce, n_valid);
        end
    endtask

    initial begin
        #200000;
        n_mis++;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        go_idle(2);
        test_write();
        go_idle(2);
        test_both();
        go_idle(2);
        test_back_to_back();
        go_idle(3);
        test_mmio();
        go_idle(2);
        test_reset_mid_read();
        go_idle(2);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_mis++; $display("FAIL sb_leftover: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
